// File: rtl/bypass_pkg.sv
// Shared types and constants for the bypass-pipe scheduler.
package bypass_pkg;

  localparam int DATA_W       = 64;
  localparam int PIPE_LAT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bypass_rr_arb.sv
// Round-robin picker: one-hot grant for the first requester at or after ptr_i.
module bypass_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // NOTE: every output and helper gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bypass_sched.sv
// Schedules NUM_REQ requesters onto one fixed-latency bypass pipe and routes responses back.
// Optional consistency checker enabled by defining BYPASS_SCHED_CHK_EN.
module bypass_sched
  import bypass_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pipe_in_valid,
  output logic [DATA_W-1:0]         pipe_in_data,
  input  logic                      pipe_out_valid,
  input  logic [DATA_W-1:0]         pipe_out_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy,
  output logic [1:0]                state,
  output logic                      err_flag
);

  localparam int              ID_W    = $clog2(NUM_REQ);
  localparam int              CNT_W   = $clog2(PIPE_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPE_LAT + 1);

  state_e                         state_q, state_d;
  logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]             gnt;
  logic                           xfer;
  logic [ID_W-1:0]                xfer_id;
  logic                           pin_v_q;
  logic [DATA_W-1:0]              pin_d_q;
  logic [ID_W-1:0]                pin_id_q;
  logic [PIPE_LAT-1:0]            tag_vld_q;
  logic [PIPE_LAT-1:0][ID_W-1:0]  tag_id_q;
  logic [CNT_W-1:0]               infl_q, infl_d;
  logic                           tail_vld;
  logic [ID_W-1:0]                tail_id;

  bypass_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    req_ready = (state_q == RUN) ? gnt : '0;
    xfer      = |(req_valid & req_ready);
    xfer_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) xfer_id = ID_W'(i);
    end
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (xfer_id == ID_W'(NUM_REQ - 1)) ? '0 : xfer_id + ID_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_enable) state_d = RUN;
      RUN:     if (!cfg_enable) state_d = DRAIN;
      DRAIN: begin
        if (cfg_enable)                      state_d = RUN;
        else if (infl_q == '0 && !pin_v_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous launch and return leave the count unchanged; both ends saturate.
  always_comb begin
    infl_d = infl_q;
    if (pin_v_q && !pipe_out_valid) begin
      if (infl_q != CNT_MAX) infl_d = infl_q + CNT_W'(1);
    end else if (!pin_v_q && pipe_out_valid) begin
      if (infl_q != '0) infl_d = infl_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      infl_q    <= '0;
      pin_v_q   <= 1'b0;
      pin_d_q   <= '0;
      tag_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      infl_q   <= infl_d;
      pin_v_q  <= xfer;
      if (xfer) pin_d_q <= req_data[xfer_id*DATA_W +: DATA_W];
      tag_vld_q[0] <= pin_v_q;
      for (int i = 1; i < PIPE_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
    end
  end

  // NOTE: tag ids are payload qualified by tag_vld_q, so this shift register carries no reset.
  always_ff @(posedge clk) begin
    if (xfer) pin_id_q <= xfer_id;
    tag_id_q[0] <= pin_id_q;
    for (int i = 1; i < PIPE_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  assign tail_vld = tag_vld_q[PIPE_LAT-1];
  assign tail_id  = tag_id_q[PIPE_LAT-1];

  // A return with no live tag (e.g. after a reset mid-flight) is dropped.
  always_comb begin
    resp_valid = '0;
    if (pipe_out_valid && tail_vld) resp_valid[tail_id] = 1'b1;
  end

  assign resp_data     = pipe_out_data;
  assign pipe_in_valid = pin_v_q;
  assign pipe_in_data  = pin_d_q;
  assign busy          = (infl_q != '0);
  assign state         = state_q;

`ifdef BYPASS_SCHED_CHK_EN
  logic err_q;
  logic underflow;

  assign underflow = pipe_out_valid && !pin_v_q && (infl_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | (pipe_out_valid != tail_vld) | underflow;
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_bypass_sched.sv
// Directed scoreboard bench for bypass_sched with a behavioural loop-back pipe.
module tb_bypass_sched;
  import bypass_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 8;
  localparam logic CHK =
`ifdef BYPASS_SCHED_CHK_EN
    1'b1;
`else
    1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cfg_enable;
  logic [N-1:0]      req_valid;
  logic [N*64-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              pipe_in_valid;
  logic [63:0]       pipe_in_data;
  logic              pipe_out_valid;
  logic [63:0]       pipe_out_data;
  logic [N-1:0]      resp_valid;
  logic [63:0]       resp_data;
  logic              busy;
  logic [1:0]        state;
  logic              err_flag;

  always #5 clk = ~clk;

  bypass_sched #(.NUM_REQ(N), .PIPE_LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_enable     (cfg_enable),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_data   (pipe_in_data),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_data  (pipe_out_data),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .busy           (busy),
    .state          (state),
    .err_flag       (err_flag)
  );

  // Behavioural shared pipe: not reset, so launched items still return after a DUT reset.
  logic [LAT-1:0] sr_v = '0;
  logic [63:0]    sr_d [LAT];
  logic           inj_v = 1'b0;
  logic [63:0]    inj_d = '0;

  always @(posedge clk) begin
    sr_v     <= {sr_v[LAT-2:0], pipe_in_valid};
    sr_d[0]  <= pipe_in_data;
    for (int i = 1; i < LAT; i++) sr_d[i] <= sr_d[i-1];
  end

  assign pipe_out_valid = sr_v[LAT-1] | inj_v;
  assign pipe_out_data  = inj_v ? inj_d : sr_d[LAT-1];

  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  state_e      m_state;
  int          m_ptr;
  logic        m_pin_v;
  logic [63:0] m_pin_d;
  int          m_infl;
  logic        m_err;
  int          cyc;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input int ptr);
    logic [2*N-1:0] rot;
    rot = {v, v} >> ptr;
    for (int k = 0; k < N; k++) begin
      if (rot[k]) return N'(1) << ((ptr + k) % N);
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_state = IDLE;
    m_ptr   = 0;
    m_pin_v = 1'b0;
    m_pin_d = '0;
    m_infl  = 0;
    m_err   = 1'b0;
    sb.delete();
  endtask

  // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic tick();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         pov;
    logic         tail;
    logic         und;
    int           gid;
    state_e       ns;
    exp_t         e;
    @(negedge clk);
    eg = (m_state == RUN) ? model_gnt(req_valid, m_ptr) : '0;
    check("req_ready", 64'(req_ready), 64'(eg));
    check("state", 64'(state), 64'(m_state));
    check("busy", 64'(busy), 64'(m_infl != 0));
    check("err_flag", 64'(err_flag), 64'(m_err));
    check("pipe_in_valid", 64'(pipe_in_valid), 64'(m_pin_v));
    if (m_pin_v) check("pipe_in_data", pipe_in_data, m_pin_d);
    pov  = pipe_out_valid;
    tail = (sb.size() > 0) && (sb[0].due == cyc);
    er   = '0;
    if (tail) begin
      e = sb.pop_front();
      if (pov) begin
        er[e.id] = 1'b1;
        check("resp_data", resp_data, e.data);
      end
    end
    check("resp_valid", 64'(resp_valid), 64'(er));

    ns = m_state;
    case (m_state)
      IDLE:    if (cfg_enable) ns = RUN;
      RUN:     if (!cfg_enable) ns = DRAIN;
      default: if (cfg_enable) ns = RUN;
               else if (m_infl == 0 && !m_pin_v) ns = IDLE;
    endcase

    und = 1'b0;
    if (m_pin_v && !pov)      m_infl = (m_infl == LAT + 1) ? m_infl : m_infl + 1;
    else if (!m_pin_v && pov) begin
      if (m_infl == 0) und = 1'b1;
      else             m_infl = m_infl - 1;
    end
    if (CHK) m_err = m_err | (pov != tail) | und;

    m_pin_v = |eg;
    if (|eg) begin
      gid = 0;
      for (int i = 0; i < N; i++) if (eg[i]) gid = i;
      m_pin_d = req_data[gid*64 +: 64];
      sb.push_back('{id: gid, data: req_data[gid*64 +: 64], due: cyc + 1 + LAT});
      m_ptr = (gid + 1) % N;
    end
    m_state = ns;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_pipe_in_valid", 64'(pipe_in_valid), 64'(0));
    check("rst_pipe_in_data", pipe_in_data, 64'(0));
    check("rst_err_flag", 64'(err_flag), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    cfg_enable = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    cyc        = 0;
    model_reset();
    #1;
    apply_reset();
    repeat (2) tick();

    // Single request from requester 2.
    cfg_enable = 1'b1;
    tick();
    req_valid = 4'b0100;
    req_data[2*64 +: 64] = 64'hA5;
    tick();
    req_valid = '0;
    check("single_pin_valid_t1", 64'(pipe_in_valid), 64'(1));
    check("single_pin_data_t1", pipe_in_data, 64'hA5);
    repeat (8) tick();
    check("single_resp_valid_t9", 64'(resp_valid), 64'(4'b0100));
    check("single_resp_data_t9", resp_data, 64'hA5);
    tick();

    // Requester 3 alone, which wraps the pointer back to 0.
    req_valid = 4'b1000;
    req_data[3*64 +: 64] = 64'h3333_0000_0000_3333;
    tick();
    req_valid = '0;
    repeat (10) tick();

    // Full contention for 8 cycles.
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b1111;
      for (int l = 0; l < N; l++) req_data[l*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(k * 16 + l);
      #1;
      check("contention_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
    end
    req_valid = '0;
    check("contention_busy", 64'(busy), 64'(1));
    repeat (12) tick();

    // Drain: enable drops in the cycle of the fifth transfer.
    req_valid = 4'b1111;
    for (int l = 0; l < N; l++) req_data[l*64 +: 64] = 64'hD000 + 64'(l);
    repeat (4) tick();
    cfg_enable = 1'b0;
    tick();
    #1;
    check("drain_state", 64'(state), 64'(DRAIN));
    check("drain_req_ready", 64'(req_ready), 64'(0));
    guard = 0;
    while (state !== 2'(IDLE) && guard < 40) begin
      tick();
      guard++;
    end
    check("drain_not_timed_out", 64'(guard < 40), 64'(1));
    check("drain_idle_state", 64'(state), 64'(IDLE));
    check("drain_idle_busy", 64'(busy), 64'(0));
    req_valid = '0;
    repeat (2) tick();

    // Stray return with an empty tag tail.
    inj_v = 1'b1;
    inj_d = 64'hDEAD_BEEF;
    tick();
    inj_v = 1'b0;
    check("inj_err_flag", 64'(err_flag), 64'(CHK));
    repeat (3) tick();
    check("inj_err_held", 64'(err_flag), 64'(CHK));

    // Reset with three items in flight; their returns must be dropped.
    cfg_enable = 1'b1;
    tick();
    req_valid = 4'b1111;
    for (int l = 0; l < N; l++) req_data[l*64 +: 64] = 64'hE000 + 64'(l);
    repeat (3) tick();
    req_valid  = '0;
    cfg_enable = 1'b0;
    repeat (2) tick();
    apply_reset();
    repeat (12) tick();

    // Normal operation after reset.
    cfg_enable = 1'b1;
    tick();
    req_valid = 4'b0001;
    req_data[0 +: 64] = 64'h1234_5678_9ABC_DEF0;
    tick();
    req_valid = '0;
    repeat (10) tick();
    check("final_scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
